// File: rtl/text_pkg.sv
// Shared constants, character codes, FSM state type and address helpers
// for the character-cell text screen.
package text_pkg;

  localparam int CELL_SHIFT = 4;
  localparam int COLS       = 30;
  localparam int ROWS       = 17;
  localparam int ADDR_W     = 9;

  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_NL     = 8'h0A;
  localparam logic [7:0] CH_BS     = 8'h08;
  localparam logic [7:0] CH_CURSOR = 8'h5F;

  // Address of the bottom-right cell; the clear walk stops here.
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    HOLD
  } state_t;

  // row*30 + col without a multiplier. Modulo-512 arithmetic is exact here
  // because the true result never exceeds 509.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] row,
                                                  input logic [4:0] col);
    logic [ADDR_W-1:0] r;
    r = {4'b0, row};
    return (r << 5) - (r << 1) + {4'b0, col};
  endfunction

  // Next text row; the screen wraps to the top instead of scrolling.
  function automatic logic [4:0] next_row(input logic [4:0] row);
    return (row == 5'(ROWS - 1)) ? 5'd0 : row + 5'd1;
  endfunction

endpackage

// File: rtl/text_buf_ram.sv
// 512x8 simple dual-port text buffer: one write port, one registered
// read-first read port.
import text_pkg::*;

module text_buf_ram (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [0:(1 << ADDR_W) - 1];

  // Write and read share the edge; a same-address read sees the old byte.
  // NOTE: the array has no reset so it maps onto block RAM; the controller
  // re-clears it after every reset instead.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_screen_ctrl.sv
// Text screen scheduler: owns the 30x17 character buffer, applies cursor
// moves for incoming characters, clears the screen, and supplies CharDraw
// with cell origin and character code one cycle after each scan pixel.
import text_pkg::*;

module text_screen_ctrl #(
  parameter int          H_RES     = 480,
  parameter int          V_RES     = 272,
  parameter logic [23:0] BLINK_DIV = 24'd12_000_000
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic [9:0] x,
  input  logic [8:0] y,
  input  logic       char_valid,
  input  logic [7:0] char_in,
  output logic       char_ready,
  input  logic       cmd_clear,
  output logic [9:0] box_x,
  output logic [8:0] box_y,
  output logic [7:0] char_out,
  output logic [4:0] cur_col,
  output logic [4:0] cur_row,
  output logic       busy
);

  localparam logic [9:0] H_LIM = 10'(H_RES);
  localparam logic [8:0] V_LIM = 9'(V_RES);

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic [23:0]       blink_cnt;
  logic              blink_phase;

  logic              accept;
  logic [4:0]        nxt_col;
  logic [4:0]        nxt_row;
  logic              we;
  logic              we_gated;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata;

  logic [5:0]        rd_col;
  logic [4:0]        rd_row;
  logic              in_frame;
  logic              cursor_here;
  logic [ADDR_W-1:0] raddr;
  logic [7:0]        rdata;
  logic              valid_q;
  logic              hit_q;

  // A clear request wins over a character offered in the same cycle.
  assign char_ready = (state == IDLE) && !cmd_clear;
  assign busy       = (state == CLEAR);
  assign accept     = char_valid && char_ready;

  // Next cursor position and buffer write for the current cycle.
  // NOTE: every output gets a default first so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    nxt_col = cur_col;
    nxt_row = cur_row;
    we      = 1'b0;
    waddr   = cell_addr(cur_row, cur_col);
    wdata   = CH_SPACE;
    if (state == CLEAR) begin
      we    = 1'b1;
      waddr = clr_addr;
    end else if (accept) begin
      case (char_in)
        CH_NL: begin
          nxt_col = 5'd0;
          nxt_row = next_row(cur_row);
        end
        CH_BS: begin
          if (cur_col != 5'd0) begin
            nxt_col = cur_col - 5'd1;
          end else if (cur_row != 5'd0) begin
            nxt_col = 5'(COLS - 1);
            nxt_row = cur_row - 5'd1;
          end
          // Home position: the cursor stays and nothing is erased.
          we    = (cur_col != 5'd0) || (cur_row != 5'd0);
          waddr = cell_addr(nxt_row, nxt_col);
        end
        default: begin
          we    = 1'b1;
          wdata = char_in;
          if (cur_col == 5'(COLS - 1)) begin
            nxt_col = 5'd0;
            nxt_row = next_row(cur_row);
          end else begin
            nxt_col = cur_col + 5'd1;
          end
        end
      endcase
    end
  end

  // Reset held low must not leave stray writes in the buffer.
  assign we_gated = we && rstb;

  // Control FSM: clear walk, cursor update on accepted characters.
  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= CLEAR;
      clr_addr <= '0;
      cur_col  <= 5'd0;
      cur_row  <= 5'd0;
    end else if (cmd_clear) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cur_col <= nxt_col;
            cur_row <= nxt_row;
          end
        end
        CLEAR: begin
          if (clr_addr == LAST_CELL) begin
            state   <= IDLE;
            cur_col <= 5'd0;
            cur_row <= 5'd0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Cursor blink: phase flips every BLINK_DIV clocks.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_DIV - 24'd1) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 24'd1;
    end
  end

  assign rd_col      = x[9:CELL_SHIFT];
  assign rd_row      = y[8:CELL_SHIFT];
  assign in_frame    = (x < H_LIM) && (y < V_LIM);
  assign cursor_here = (rd_col == {1'b0, cur_col}) && (rd_row == cur_row);
  assign raddr       = in_frame ? cell_addr(rd_row, rd_col[4:0]) : '0;

  // Scan pipeline stage, aligned with the RAM read register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      box_x   <= '0;
      box_y   <= '0;
      valid_q <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      box_x   <= {x[9:CELL_SHIFT], {CELL_SHIFT{1'b0}}};
      box_y   <= {y[8:CELL_SHIFT], {CELL_SHIFT{1'b0}}};
      valid_q <= in_frame;
      hit_q   <= in_frame && blink_phase && cursor_here;
    end
  end

  // Off-screen pixels draw nothing; a blank cursor cell shows an underscore.
  assign char_out = !valid_q                       ? 8'h00     :
                    (hit_q && rdata == CH_SPACE)   ? CH_CURSOR : rdata;

  text_buf_ram u_buf (
    .clk   (clk),
    .we    (we_gated),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_text_screen_ctrl.sv
// Directed bench for text_screen_ctrl with a small reference model of the
// text buffer, cursor and blink phase (BLINK_DIV = 4).
module tb_text_screen_ctrl;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic [9:0] x = '0;
  logic [8:0] y = '0;
  logic       char_valid = 1'b0;
  logic [7:0] char_in = '0;
  logic       cmd_clear = 1'b0;
  logic       char_ready;
  logic [9:0] box_x;
  logic [8:0] box_y;
  logic [7:0] char_out;
  logic [4:0] cur_col;
  logic [4:0] cur_row;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_mem [510];
  int   m_col = 0;
  int   m_row = 0;
  int   m_cnt = 0;
  logic m_phase = 1'b0;
  logic m_phase_at_edge = 1'b0;

  always #5 clk = ~clk;

  text_screen_ctrl #(.BLINK_DIV(24'd4)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .x          (x),
    .y          (y),
    .char_valid (char_valid),
    .char_in    (char_in),
    .char_ready (char_ready),
    .cmd_clear  (cmd_clear),
    .box_x      (box_x),
    .box_y      (box_y),
    .char_out   (char_out),
    .cur_col    (cur_col),
    .cur_row    (cur_row),
    .busy       (busy)
  );

  // Blink reference: phase seen by the read issued at each edge.
  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      m_cnt   = 0;
      m_phase = 1'b0;
    end else begin
      m_phase_at_edge = m_phase;
      if (m_cnt == 3) begin
        m_cnt   = 0;
        m_phase = ~m_phase;
      end else begin
        m_cnt++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < 510; i++) exp_mem[i] = 8'h20;
    m_col = 0;
    m_row = 0;
  endtask

  task automatic mdl_char(input logic [7:0] ch);
    if (ch == 8'h0A) begin
      m_col = 0;
      m_row = (m_row + 1) % 17;
    end else if (ch == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        exp_mem[m_row * 30 + m_col] = 8'h20;
      end else if (m_row > 0) begin
        m_col = 29;
        m_row--;
        exp_mem[m_row * 30 + m_col] = 8'h20;
      end
    end else begin
      exp_mem[m_row * 30 + m_col] = ch;
      m_col++;
      if (m_col == 30) begin
        m_col = 0;
        m_row = (m_row + 1) % 17;
      end
    end
  endtask

  function automatic logic [7:0] exp_char(input int px, input int py, input logic ph);
    logic [7:0] code;
    if (px >= 480 || py >= 272) return 8'h00;
    code = exp_mem[(py / 16) * 30 + px / 16];
    if (ph && (px / 16 == m_col) && (py / 16 == m_row) && code == 8'h20) return 8'h5F;
    return code;
  endfunction

  task automatic send(input logic [7:0] ch);
    char_valid = 1'b1;
    char_in    = ch;
    tick();
    char_valid = 1'b0;
    mdl_char(ch);
  endtask

  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check({tag, "_busy_cycles"}, n, 510);
    check({tag, "_ready"}, char_ready, 1);
    check({tag, "_col"}, cur_col, 0);
    check({tag, "_row"}, cur_row, 0);
    mdl_clear();
  endtask

  task automatic read_at(input string tag, input int px, input int py);
    x = 10'(px);
    y = 9'(py);
    tick();
    check({tag, "_char"}, char_out, exp_char(px, py, m_phase_at_edge));
    check({tag, "_box_x"}, box_x, (px / 16) * 16);
    check({tag, "_box_y"}, box_y, (py / 16) * 16);
  endtask

  task automatic scan(input string tag);
    int bad;
    bad = 0;
    for (int py = 0; py < 272; py += 4) begin
      for (int px = 0; px < 480; px += 4) begin
        x = 10'(px);
        y = 9'(py);
        tick();
        if (char_out !== exp_char(px, py, m_phase_at_edge) ||
            box_x !== 10'((px / 16) * 16) || box_y !== 9'((py / 16) * 16))
          bad++;
      end
    end
    check(tag, bad, 0);
  endtask

  initial begin
    mdl_clear();

    // 1: reset state, power-up clear, blank frame with blinking cursor
    repeat (3) tick();
    check("rst_box_x", box_x, 0);
    check("rst_box_y", box_y, 0);
    check("rst_char_out", char_out, 0);
    check("rst_cur_col", cur_col, 0);
    check("rst_cur_row", cur_row, 0);
    check("rst_busy", busy, 1);
    check("rst_ready", char_ready, 0);
    #3 rstb = 1'b1;
    wait_clear("init");
    for (int i = 0; i < 8; i++) read_at("blink", 3, 7);
    scan("scan_init");
    read_at("last_pixel", 479, 271);
    read_at("x_edge", 480, 0);
    read_at("y_edge", 0, 272);

    // 2: two characters, read-back, off-screen, read-first
    send(8'h41);
    send(8'h42);
    check("ab_col", cur_col, 2);
    check("ab_row", cur_row, 0);
    x = 10'd16;
    y = 9'd5;
    tick();
    check("ab_char", char_out, 8'h42);
    check("ab_box_x", box_x, 16);
    check("ab_box_y", box_y, 0);
    x = 10'd500;
    tick();
    check("off_char", char_out, 8'h00);
    check("off_box_x", box_x, 496);
    x = 10'd32;
    y = 9'd0;
    send(8'h43);
    check("rf_old", char_out, m_phase_at_edge ? 8'h5F : 8'h20);
    tick();
    check("rf_new", char_out, 8'h43);

    // 3: line wrap, newline, row wrap
    cmd_clear = 1'b1;
    tick();
    cmd_clear = 1'b0;
    wait_clear("clr_a");
    for (int i = 0; i < 30; i++) send(8'(8'h30 + i));
    check("wrap_col", cur_col, 0);
    check("wrap_row", cur_row, 1);
    send(8'h0A);
    check("nl_col", cur_col, 0);
    check("nl_row", cur_row, 2);
    for (int i = 0; i < 15; i++) send(8'h0A);
    check("nl_wrap_row", cur_row, 0);
    for (int i = 0; i < 16; i++) send(8'h0A);
    check("nl16_row", cur_row, 16);
    send(8'h0A);
    check("nl17_row", cur_row, 0);
    x = 10'd464;
    y = 9'd0;
    tick();
    check("col29_char", char_out, 8'h4D);

    // 4: backspace across a row boundary and at home
    send(8'h0A);
    send(8'h08);
    check("bs_col", cur_col, 29);
    check("bs_row", cur_row, 0);
    tick();
    check("bs_cell", char_out, m_phase_at_edge ? 8'h5F : 8'h20);
    for (int i = 0; i < 29; i++) send(8'h08);
    check("bs_home_col", cur_col, 0);
    send(8'h08);
    check("bs_stay_col", cur_col, 0);
    check("bs_stay_row", cur_row, 0);
    scan("scan_bs");

    // 5: clear beats a simultaneous character; restart mid-clear
    send(8'h58);
    send(8'h59);
    cmd_clear  = 1'b1;
    char_valid = 1'b1;
    char_in    = 8'h51;
    #1;
    check("clr_pri_ready", char_ready, 0);
    tick();
    cmd_clear  = 1'b0;
    char_valid = 1'b0;
    check("clr_pri_col_held", cur_col, 2);
    check("clr_pri_busy", busy, 1);
    wait_clear("clr_pri");
    cmd_clear = 1'b1;
    tick();
    cmd_clear = 1'b0;
    repeat (300) tick();
    check("restart_busy", busy, 1);
    cmd_clear = 1'b1;
    tick();
    cmd_clear = 1'b0;
    wait_clear("restart");

    // 6: asynchronous reset in the middle of a clear
    send(8'h41);
    send(8'h42);
    send(8'h43);
    cmd_clear = 1'b1;
    tick();
    cmd_clear = 1'b0;
    repeat (100) tick();
    x = 10'd100;
    y = 9'd100;
    tick();
    check("pre_rst_box_y", box_y, 96);
    #2 rstb = 1'b0;
    #1;
    check("arst_box_x", box_x, 0);
    check("arst_box_y", box_y, 0);
    check("arst_char_out", char_out, 0);
    check("arst_cur_col", cur_col, 0);
    check("arst_busy", busy, 1);
    check("arst_ready", char_ready, 0);
    repeat (2) tick();
    #3 rstb = 1'b1;
    wait_clear("rerst");
    scan("scan_rerst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_screen_ctrl.md
Name: text_screen_ctrl

Overview:
Character-cell scheduler that sits in front of CharDraw on the 480x272 TFT path. It owns a 30x17 text buffer and accepts decoded characters from the Morse decoder through a valid/ready handshake, handling cursor advance, newline, backspace and clear. For every scan pixel (x, y) it supplies CharDraw with the cell origin (box_x, box_y) and the character code, with fixed one-cycle latency.

Parameters:
H_RES, 480, active pixels per line
V_RES, 272, active lines
COLS, 30, text columns (H_RES/16)
ROWS, 17, text rows (V_RES/16)
BLINK_DIV, 24'd12_000_000, clk cycles per cursor blink half-period

Ports:
clk  in  1  system clock
rstb  in  1  asynchronous active-low reset
x  in  10  current scan column
y  in  9  current scan line
char_valid  in  1  char_in is offered
char_in  in  8  character code; 8'h0A is newline, 8'h08 is backspace
char_ready  out  1  block can accept char_in this cycle
cmd_clear  in  1  single-cycle pulse; blanks the screen and homes the cursor
box_x  out  10  origin x of the cell under (x, y), registered
box_y  out  9  origin y of the cell under (x, y), registered
char_out  out  8  character to draw in that cell, registered
cur_col  out  5  cursor column, 0..29
cur_row  out  5  cursor row, 0..16
busy  out  1  clear sequence in progress

Behaviour:
- Interface: one clock, clk; reset rstb is asynchronous and active-low.
- Reset values: box_x=0, box_y=0, char_out=0, cur_col=0, cur_row=0, blink counter=0, blink phase=0. The FSM enters CLEAR with clear address 0, so busy=1 and char_ready=0.
- Cell size is fixed at 16x16. Cell column is x[9:4] and cell row is y[8:4].
- Buffer address is row*30+col, computed as (row<<5)-(row<<1)+col, 9 bits wide.
- Buffer storage: 512x8 simple dual-port RAM, holding 510 valid cells.
- FSM has three states: IDLE, CLEAR and HOLD.
- IDLE:
  - char_ready=1.
  - An accept occurs when char_valid && char_ready.
  - Printable code: write it at the cursor, then advance cur_col. If cur_col reaches 30, set cur_col to 0 and increment cur_row. If cur_row passes 16, wrap to row 0 (no scroll).
  - 8'h0A: cur_col becomes 0 and cur_row advances with the same wrap rule. Nothing is written.
  - 8'h08: if cur_col>0, decrement it; otherwise, if cur_row>0, go to col 29 of row-1. The new cursor cell is written with 8'h20. At (0,0), backspace does nothing.
- cmd_clear is sampled in any state. It enters CLEAR with address 0 and takes priority over a simultaneous accept; that character is dropped and char_ready is 0 that cycle.
- CLEAR:
  - Writes 8'h20 to address 0..509, one address per cycle, so the sequence lasts 510 cycles.
  - busy=1 and char_ready=0 throughout.
  - After address 509, the cursor goes to (0,0) and the FSM moves to IDLE.
  - A cmd_clear during CLEAR restarts it at address 0.
- HOLD is reserved. Any entry to HOLD returns the FSM to IDLE next cycle.
- Read pipeline:
  - On each clk, (x, y) is registered into box_x={x[9:4],4'b0} and box_y={y[8:4],4'b0}.
  - char_out is the RAM read data, giving latency of exactly 1 cycle.
  - If x>=480 or y>=272, char_out=8'h00 and box_x and box_y hold the computed values.
  - Same-address read/write returns the old data (read-first). The new value is visible on the next read.
- Cursor blink:
  - The counter counts 0..BLINK_DIV-1 and toggles the blink phase on wrap.
  - When the phase is 1, the read cell equals the cursor cell and the stored code is 8'h20, char_out is 8'h5F.
- Reset asserted mid-operation aborts any write and returns the block to the reset state. The buffer contents are don't-care until the re-clear completes.

Decomposition:
- Shared package text_pkg:
  - constants CELL_SHIFT=4, COLS=30, ROWS=17, ADDR_W=9
  - codes CH_SPACE=8'h20, CH_NL=8'h0A, CH_BS=8'h08, CH_CURSOR=8'h5F
  - the FSM state enum
- One sub-module, text_buf_ram: 512x8, write port (we, waddr, wdata) and registered read-first read port (raddr, rdata).
- The cursor and FSM logic stay in text_screen_ctrl.

Test Plan:
1. Release rstb -> busy=1 for exactly 510 cycles, then char_ready=1; a full-frame scan (x 0..479, y 0..271) yields char_out=8'h20 everywhere, except 8'h5F at (0,0) when the phase is 1 (BLINK_DIV=4 in the bench).
2. Send 'A','B' (8'h41, 8'h42) -> cursor=(2,0); x=16, y=5 gives box_x=16, box_y=0, char_out=8'h42 one cycle later; x=500 gives char_out=8'h00.
3. Send 30 printable characters, then 8'h0A -> the cursor wraps to (0,1) after the 30th and the newline moves it to (0,2); after 17 newlines from row 0 the cursor is (0,0).
4. Cursor at (0,1): send 8'h08 -> cursor=(29,0) and cell 29 reads 8'h20; at (0,0), backspace leaves the cursor at (0,0).
5. Assert cmd_clear in the same cycle as char_valid=1 -> the character is not written, busy=1 for 510 cycles, and the cursor ends at (0,0); cmd_clear at clear address 300 restarts the count.
6. Assert rstb=0 mid-clear -> outputs return to reset values asynchronously; after release, a full 510-cycle clear is observed.
